// File: rtl/spi_master_controller.sv
// Mode-0 SPI initiator: frames one CMD / ADDR / DUMMY / DATA transaction per valid/ready request.
// Optional SPI_MASTER_BURST_EN adds multi-word DATA bursts (req_len, wdata_valid/wdata_ready).
module spi_master_controller #(
  parameter int CLK_DIV    = 2,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [7:0]            req_cmd,
  input  logic                  req_has_addr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [7:0]            req_dummy,
  input  logic                  req_read,
  input  logic [DATA_WIDTH-1:0] req_wdata,
`ifdef SPI_MASTER_BURST_EN
  input  logic [7:0]            req_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
`endif
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic                  sclk,
  output logic                  cs,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int SW0 = (ADDR_WIDTH > 8) ? ADDR_WIDTH : 8;
  localparam int SW  = (DATA_WIDTH > SW0) ? DATA_WIDTH : SW0;

  typedef enum logic [2:0] {IDLE, SETUP, CMD, ADDR, DUMMY, DATA, HOLD, GAP} state_t;
  state_t state_q, state_d, nxt_phase;

  logic [7:0]            div_cnt;
  logic [15:0]           bit_cnt;
  logic [SW-1:0]         tx_sr;     // bits still to go out after the one on mosi
  logic [DATA_WIDTH-1:0] rx_sr;
  logic                  sh_has_addr, sh_read;
  logic [ADDR_WIDTH-1:0] sh_addr;
  logic [7:0]            sh_dummy;
  logic [DATA_WIDTH-1:0] sh_wdata;
  logic                  stall, more_words;
  logic                  tick, shifting, rise, fall, phase_end, quiet;

`ifdef SPI_MASTER_BURST_EN
  logic [7:0] word_cnt;
  logic       rx_pend;
  assign more_words  = (word_cnt != 8'd0);
  assign wdata_ready = (state_q == DATA) && !sh_read && more_words && (phase_end || stall);
`else
  assign stall      = 1'b0;
  assign more_words = 1'b0;
`endif

  assign shifting  = (state_q == CMD) || (state_q == ADDR) || (state_q == DUMMY) || (state_q == DATA);
  assign tick      = (state_q != IDLE) && !stall && (div_cnt == 8'(CLK_DIV - 1));
  assign rise      = tick && shifting && !sclk;
  assign fall      = tick && shifting && sclk;
  assign phase_end = fall && (bit_cnt == 16'd1);
  assign quiet     = (state_q == DUMMY) || ((state_q == DATA) && sh_read);

  always_comb begin
    nxt_phase = HOLD;
    case (state_q)
      CMD:     nxt_phase = sh_has_addr ? ADDR : ((sh_dummy != 8'd0) ? DUMMY : DATA);
      ADDR:    nxt_phase = (sh_dummy != 8'd0) ? DUMMY : DATA;
      DUMMY:   nxt_phase = DATA;
      DATA:    nxt_phase = more_words ? DATA : HOLD;
      default: nxt_phase = HOLD;
    endcase
    state_d = state_q;
    case (state_q)
      IDLE:                   if (req_valid && req_ready) state_d = SETUP;
      SETUP:                  if (tick) state_d = CMD;
      CMD, ADDR, DUMMY, DATA: if (phase_end) state_d = nxt_phase;
      HOLD:                   if (tick) state_d = GAP;
      GAP:                    if (tick) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      sh_has_addr <= 1'b0;
      sh_read     <= 1'b0;
      sh_addr     <= '0;
      sh_dummy    <= '0;
      sh_wdata    <= '0;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      sclk        <= 1'b0;
      cs          <= 1'b1;
      mosi        <= 1'b0;
`ifdef SPI_MASTER_BURST_EN
      word_cnt    <= '0;
      rx_pend     <= 1'b0;
      stall       <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rsp_valid <= 1'b0;
      if (state_q == IDLE || stall || tick) div_cnt <= '0;
      else                                  div_cnt <= div_cnt + 8'd1;
      case (state_q)
        IDLE: if (req_valid && req_ready) begin
          sh_has_addr <= req_has_addr;
          sh_read     <= req_read;
          sh_addr     <= req_addr;
          sh_dummy    <= req_dummy;
          sh_wdata    <= req_wdata;
          tx_sr       <= SW'(req_cmd) << (SW - 8 + 1);
          mosi        <= req_cmd[7];
          bit_cnt     <= 16'd8;
          cs          <= 1'b0;
          req_ready   <= 1'b0;
          busy        <= 1'b1;
`ifdef SPI_MASTER_BURST_EN
          word_cnt    <= req_len;
`endif
        end
        CMD, ADDR, DUMMY, DATA: begin
          if (rise) begin
            sclk <= 1'b1;
            if (state_q == DATA && sh_read) begin
              rx_sr <= DATA_WIDTH'({rx_sr, miso});
`ifdef SPI_MASTER_BURST_EN
              // previous burst word is complete until this edge shifts in the next one
              if (rx_pend) begin
                rsp_rdata <= rx_sr;
                rsp_valid <= 1'b1;
                rx_pend   <= 1'b0;
              end
`endif
            end
          end
          if (fall) begin
            sclk <= 1'b0;
            if (bit_cnt == 16'd1) begin
              bit_cnt <= 16'(DATA_WIDTH);
              mosi    <= 1'b0;
              case (nxt_phase)
                ADDR: begin
                  tx_sr   <= SW'(sh_addr) << (SW - ADDR_WIDTH + 1);
                  mosi    <= sh_addr[ADDR_WIDTH-1];
                  bit_cnt <= 16'(ADDR_WIDTH);
                end
                DUMMY: bit_cnt <= 16'(sh_dummy);
                DATA: begin
`ifdef SPI_MASTER_BURST_EN
                  if (state_q == DATA) begin
                    word_cnt <= word_cnt - 8'd1;
                    if (sh_read) rx_pend <= 1'b1;
                    else if (wdata_valid) begin
                      tx_sr <= SW'(req_wdata) << (SW - DATA_WIDTH + 1);
                      mosi  <= req_wdata[DATA_WIDTH-1];
                    end else stall <= 1'b1;
                  end else
`endif
                  begin
                    tx_sr <= SW'(sh_wdata) << (SW - DATA_WIDTH + 1);
                    mosi  <= !sh_read && sh_wdata[DATA_WIDTH-1];
                  end
                end
                default: ;
              endcase
            end else begin
              tx_sr   <= tx_sr << 1;
              mosi    <= !quiet && tx_sr[SW-1];
              bit_cnt <= bit_cnt - 16'd1;
            end
          end
`ifdef SPI_MASTER_BURST_EN
          if (stall && wdata_valid) begin
            tx_sr <= SW'(req_wdata) << (SW - DATA_WIDTH + 1);
            mosi  <= req_wdata[DATA_WIDTH-1];
            stall <= 1'b0;
          end
`endif
        end
        HOLD: if (tick) begin
          cs <= 1'b1;
          if (sh_read) begin
            rsp_rdata <= rx_sr;
            rsp_valid <= 1'b1;
          end
        end
        GAP: if (tick) begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_controller.sv
// Directed bench for spi_master_controller: CLK_DIV=2 instance plus a CLK_DIV=1 instance, each with a mode-0 slave model.
module tb_spi_master_controller;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic v0 = 1'b0, v1 = 1'b0;
  logic [7:0] cmd = '0, dmy = '0, wd = '0;
  logic ha = 1'b0, rd = 1'b0;
  logic [11:0] addr = '0;
  logic rdy0, rdy1, rv0, rv1, busy0, busy1, sclk0, sclk1, cs0, cs1, mosi0, mosi1, miso0, miso1;
  logic [7:0] rdat0, rdat1;
  int vecs = 0, errs = 0;

  spi_master_controller #(.CLK_DIV(2), .ADDR_WIDTH(12), .DATA_WIDTH(8)) u0 (
    .sys_clk(clk), .sys_rst(rst), .req_valid(v0), .req_ready(rdy0), .req_cmd(cmd),
    .req_has_addr(ha), .req_addr(addr), .req_dummy(dmy), .req_read(rd), .req_wdata(wd),
    .rsp_valid(rv0), .rsp_rdata(rdat0), .busy(busy0), .sclk(sclk0), .cs(cs0),
    .mosi(mosi0), .miso(miso0));

  spi_master_controller #(.CLK_DIV(1), .ADDR_WIDTH(12), .DATA_WIDTH(8)) u1 (
    .sys_clk(clk), .sys_rst(rst), .req_valid(v1), .req_ready(rdy1), .req_cmd(cmd),
    .req_has_addr(ha), .req_addr(addr), .req_dummy(dmy), .req_read(rd), .req_wdata(wd),
    .rsp_valid(rv1), .rsp_rdata(rdat1), .busy(busy1), .sclk(sclk1), .cs(cs1),
    .mosi(mosi1), .miso(miso1));

  // slave models: count sclk rising edges per frame, capture mosi, return srd MSB first after pre bits
  int rise0 = 0, rise1 = 0, pre0 = 99, pre1 = 99;
  logic [7:0] srd0 = '0, srd1 = '0;
  logic [63:0] mcap0 = '0, mcap1 = '0;
  logic sd0 = 1'b0, cd0 = 1'b1, sd1 = 1'b0, cd1 = 1'b1;

  always @(posedge clk) begin
    sd0 <= sclk0; cd0 <= cs0; sd1 <= sclk1; cd1 <= cs1;
    if (cd0 && !cs0) begin rise0 <= 0; mcap0 <= '0; end
    else if (sclk0 && !sd0) begin rise0 <= rise0 + 1; mcap0 <= {mcap0[62:0], mosi0}; end
    if (cd1 && !cs1) begin rise1 <= 0; mcap1 <= '0; end
    else if (sclk1 && !sd1) begin rise1 <= rise1 + 1; mcap1 <= {mcap1[62:0], mosi1}; end
  end

  assign miso0 = (rise0 >= pre0 && rise0 < pre0 + 8) ? srd0[3'(7 - (rise0 - pre0))] : 1'b0;
  assign miso1 = (rise1 >= pre1 && rise1 < pre1 + 8) ? srd1[3'(7 - (rise1 - pre1))] : 1'b0;

  task automatic start_req(input bit sel, input logic [7:0] c, input bit h, input logic [11:0] a,
                           input logic [7:0] d, input bit r, input logic [7:0] w, input bit keep);
    @(posedge clk); #1;
    cmd = c; ha = h; addr = a; dmy = d; rd = r; wd = w;
    if (sel) v1 = 1'b1; else v0 = 1'b1;
    @(posedge clk); #1;
    if (!keep) begin v0 = 1'b0; v1 = 1'b0; end
  endtask

  // starts #1 after the acceptance edge; cyc = edges until req_ready seen high again
  task automatic wait_done(input bit sel, output int cyc, output int lo, output int hi,
                           output int rsp, output int bad, output int tog);
    logic pcs, psc, ccs, csc;
    cyc = 0; lo = 0; hi = 0; rsp = 0; bad = 0; tog = 0;
    pcs = sel ? cs1 : cs0;
    psc = sel ? sclk1 : sclk0;
    while ((sel ? rdy1 : rdy0) !== 1'b1 && cyc < 3000) begin
      if ((sel ? cs1 : cs0) === 1'b0) lo++;
      @(posedge clk); #1;
      cyc++;
      ccs = sel ? cs1 : cs0;
      csc = sel ? sclk1 : sclk0;
      if (csc !== psc) tog++;
      if (ccs === 1'b1) hi++;
      if ((sel ? rv1 : rv0) === 1'b1) begin
        rsp++;
        if (!(ccs === 1'b1 && pcs === 1'b0)) bad++;
      end
      pcs = ccs; psc = csc;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vecs++; if (cs0 !== 1'b1) begin errs++; $display("FAIL rst_cs got %b exp 1", cs0); end
    vecs++; if (sclk0 !== 1'b0) begin errs++; $display("FAIL rst_sclk got %b exp 0", sclk0); end
    vecs++; if (mosi0 !== 1'b0) begin errs++; $display("FAIL rst_mosi got %b exp 0", mosi0); end
    vecs++; if (rdy0 !== 1'b1) begin errs++; $display("FAIL rst_ready got %b exp 1", rdy0); end
    vecs++; if (busy0 !== 1'b0) begin errs++; $display("FAIL rst_busy got %b exp 0", busy0); end
    vecs++; if (rv0 !== 1'b0) begin errs++; $display("FAIL rst_rsp_valid got %b exp 0", rv0); end
    vecs++; if (rdat0 !== 8'h00) begin errs++; $display("FAIL rst_rdata got %h exp 00", rdat0); end
    vecs++; if (cs1 !== 1'b1 || rdy1 !== 1'b1) begin errs++; $display("FAIL rst_u1 got cs=%b rdy=%b exp 1 1", cs1, rdy1); end
    rst = 1'b0;
  endtask

  task automatic test_write();
    int cyc, lo, hi, rsp, bad, tog;
    pre0 = 99;
    start_req(0, 8'h02, 1, 12'h0A5, 8'd0, 0, 8'h3C, 0);
    vecs++; if (busy0 !== 1'b1 || rdy0 !== 1'b0 || cs0 !== 1'b0) begin errs++; $display("FAIL wr_accept got busy=%b rdy=%b cs=%b exp 1 0 0", busy0, rdy0, cs0); end
    wait_done(0, cyc, lo, hi, rsp, bad, tog);
    vecs++; if (cyc != 118) begin errs++; $display("FAIL wr_ready_time got %0d exp 118", cyc); end
    vecs++; if (lo != 116) begin errs++; $display("FAIL wr_cs_low got %0d exp 116", lo); end
    vecs++; if (rise0 != 28) begin errs++; $display("FAIL wr_sclk_rises got %0d exp 28", rise0); end
    vecs++; if (mcap0[27:0] !== 28'h020A53C) begin errs++; $display("FAIL wr_bits got %h exp 020a53c", mcap0[27:0]); end
    vecs++; if (rsp != 0) begin errs++; $display("FAIL wr_no_rsp got %0d exp 0", rsp); end
  endtask

  task automatic test_read_dummy();
    int cyc, lo, hi, rsp, bad, tog;
    pre0 = 28; srd0 = 8'h96;
    start_req(0, 8'h0B, 1, 12'h123, 8'd8, 1, 8'hFF, 0);
    wait_done(0, cyc, lo, hi, rsp, bad, tog);
    vecs++; if (cyc != 150) begin errs++; $display("FAIL rdd_ready_time got %0d exp 150", cyc); end
    vecs++; if (lo != 148) begin errs++; $display("FAIL rdd_cs_low got %0d exp 148", lo); end
    vecs++; if (rise0 != 36) begin errs++; $display("FAIL rdd_sclk_rises got %0d exp 36", rise0); end
    vecs++; if (mcap0[35:0] !== 36'h0B1230000) begin errs++; $display("FAIL rdd_bits got %h exp 0b1230000", mcap0[35:0]); end
    vecs++; if (rsp != 1 || bad != 0) begin errs++; $display("FAIL rdd_rsp got n=%0d misaligned=%0d exp 1 0", rsp, bad); end
    vecs++; if (rdat0 !== 8'h96) begin errs++; $display("FAIL rdd_rdata got %h exp 96", rdat0); end
  endtask

  task automatic test_no_addr();
    int cyc, lo, hi, rsp, bad, tog;
    pre0 = 8; srd0 = 8'hA1;
    start_req(0, 8'h05, 0, 12'hFFF, 8'd0, 1, 8'hFF, 0);
    wait_done(0, cyc, lo, hi, rsp, bad, tog);
    vecs++; if (cyc != 70) begin errs++; $display("FAIL na_ready_time got %0d exp 70", cyc); end
    vecs++; if (rise0 != 16) begin errs++; $display("FAIL na_sclk_rises got %0d exp 16", rise0); end
    vecs++; if (mcap0[15:0] !== 16'h0500) begin errs++; $display("FAIL na_bits got %h exp 0500", mcap0[15:0]); end
    vecs++; if (rsp != 1 || bad != 0) begin errs++; $display("FAIL na_rsp got n=%0d misaligned=%0d exp 1 0", rsp, bad); end
    vecs++; if (rdat0 !== 8'hA1) begin errs++; $display("FAIL na_rdata got %h exp a1", rdat0); end
  endtask

  task automatic test_back_to_back();
    int cyc, lo, hi, rsp, bad, tog;
    pre0 = 99;
    start_req(0, 8'h12, 1, 12'h3C4, 8'd0, 0, 8'h81, 1);
    // second request presented mid-frame; shadow registers must keep frame A intact
    cmd = 8'h34; ha = 1'b0; addr = 12'h000; dmy = 8'd0; rd = 1'b0; wd = 8'hE7;
    wait_done(0, cyc, lo, hi, rsp, bad, tog);
    vecs++; if (cyc != 118) begin errs++; $display("FAIL b2b_a_time got %0d exp 118", cyc); end
    vecs++; if (mcap0[27:0] !== 28'h123C481) begin errs++; $display("FAIL b2b_a_bits got %h exp 123c481", mcap0[27:0]); end
    @(posedge clk); #1;
    v0 = 1'b0;
    vecs++; if (cs0 !== 1'b0 || rdy0 !== 1'b0) begin errs++; $display("FAIL b2b_accept got cs=%b rdy=%b exp 0 0", cs0, rdy0); end
    vecs++; if (hi != 3) begin errs++; $display("FAIL b2b_cs_high got %0d exp 3", hi); end
    wait_done(0, cyc, lo, hi, rsp, bad, tog);
    vecs++; if (cyc != 70) begin errs++; $display("FAIL b2b_b_time got %0d exp 70", cyc); end
    vecs++; if (rise0 != 16) begin errs++; $display("FAIL b2b_b_rises got %0d exp 16", rise0); end
    vecs++; if (mcap0[15:0] !== 16'h34E7) begin errs++; $display("FAIL b2b_b_bits got %h exp 34e7", mcap0[15:0]); end
  endtask

  task automatic test_reset_mid();
    int cyc, lo, hi, rsp, bad, tog, nrsp;
    pre0 = 20; srd0 = 8'hC3;
    start_req(0, 8'h0B, 1, 12'h0A5, 8'd0, 1, 8'h3C, 0);
    repeat (40) @(posedge clk);
    #1;
    vecs++; if (cs0 !== 1'b0 || busy0 !== 1'b1) begin errs++; $display("FAIL rm_midframe got cs=%b busy=%b exp 0 1", cs0, busy0); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vecs++; if (cs0 !== 1'b1 || sclk0 !== 1'b0) begin errs++; $display("FAIL rm_abort got cs=%b sclk=%b exp 1 0", cs0, sclk0); end
    vecs++; if (mosi0 !== 1'b0 || rdy0 !== 1'b1) begin errs++; $display("FAIL rm_idle got mosi=%b rdy=%b exp 0 1", mosi0, rdy0); end
    nrsp = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (rv0 === 1'b1) nrsp++;
    end
    vecs++; if (nrsp != 0) begin errs++; $display("FAIL rm_no_rsp got %0d exp 0", nrsp); end
    pre0 = 8; srd0 = 8'h3C;
    start_req(0, 8'h9F, 0, 12'h000, 8'd0, 1, 8'h00, 0);
    wait_done(0, cyc, lo, hi, rsp, bad, tog);
    vecs++; if (cyc != 70) begin errs++; $display("FAIL rm_next_time got %0d exp 70", cyc); end
    vecs++; if (rsp != 1 || rdat0 !== 8'h3C) begin errs++; $display("FAIL rm_next_read got n=%0d data=%h exp 1 3c", rsp, rdat0); end
  endtask

  task automatic test_clkdiv1();
    int cyc, lo, hi, rsp, bad, tog;
    pre1 = 20; srd1 = 8'h5A;
    start_req(1, 8'h03, 1, 12'h456, 8'd0, 1, 8'hFF, 0);
    wait_done(1, cyc, lo, hi, rsp, bad, tog);
    vecs++; if (cyc != 59) begin errs++; $display("FAIL d1_ready_time got %0d exp 59", cyc); end
    vecs++; if (lo != 58) begin errs++; $display("FAIL d1_cs_low got %0d exp 58", lo); end
    vecs++; if (tog != 56) begin errs++; $display("FAIL d1_sclk_toggles got %0d exp 56", tog); end
    vecs++; if (rise1 != 28) begin errs++; $display("FAIL d1_sclk_rises got %0d exp 28", rise1); end
    vecs++; if (mcap1[27:0] !== 28'h0345600) begin errs++; $display("FAIL d1_bits got %h exp 0345600", mcap1[27:0]); end
    vecs++; if (rsp != 1 || bad != 0) begin errs++; $display("FAIL d1_rsp got n=%0d misaligned=%0d exp 1 0", rsp, bad); end
    vecs++; if (rdat1 !== 8'h5A) begin errs++; $display("FAIL d1_rdata got %h exp 5a", rdat1); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_dummy();
    test_no_addr();
    test_back_to_back();
    test_reset_mid();
    test_clkdiv1();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
